// File: rtl/divider_if.sv
`default_nettype none
// ============================================================================
// Module   : divider_if
// Purpose  : Request/response bundle between the ALU control and the divider.
// Revision : 1.0
// ============================================================================
interface divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       funct;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start, funct, operand1, operand2,
        input  result, busy, done
    );

    modport slave (
        input  start, funct, operand1, operand2,
        output result, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module   : divider
// Purpose  : Sequential restoring divider for RV32M DIV/DIVU/REM/REMU,
//            one quotient bit per clock.
// Revision : 1.0
// ============================================================================
module divider #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    divider_if.slave  bus
);
    localparam int                 c_cnt_w   = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH);
    localparam logic [1:0]         c_st_idle = 2'd0;
    localparam logic [1:0]         c_st_run  = 2'd1;
    localparam logic [1:0]         c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [c_cnt_w-1:0] r_counter;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_result;
    logic               r_is_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_special;

    logic               w_accept;
    logic               w_signed;
    logic               w_div_zero;
    logic               w_overflow;
    logic               w_finish;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_accept   = bus.start && (r_state != c_st_run);
    assign w_signed   = ~bus.funct[0];
    assign w_div_zero = (bus.operand2 == '0);
    assign w_overflow = w_signed && (bus.operand1 == {1'b1, {(WIDTH-1){1'b0}}})
                        && (bus.operand2 == '1);
    assign w_abs1     = (w_signed && bus.operand1[WIDTH-1]) ? -bus.operand1 : bus.operand1;
    assign w_abs2     = (w_signed && bus.operand2[WIDTH-1]) ? -bus.operand2 : bus.operand2;
    assign w_finish   = r_special || (r_counter == c_last);

    // Trial subtraction is one bit wider so its MSB is the borrow/sign.
    assign w_shift    = {r_rem, r_quot[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_divisor};

    // Special-case results are already final and bypass sign correction.
    assign w_quot_fix = (r_neg_q && !r_special) ? -r_quot : r_quot;
    assign w_rem_fix  = (r_neg_r && !r_special) ? -r_rem  : r_rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (bus.start) w_next = c_st_run;
            c_st_run:  if (w_finish)  w_next = c_st_done;
            c_st_done: w_next = bus.start ? c_st_run : c_st_idle;
            default:   w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counter <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_special <= 1'b0;
        end else if (w_accept) begin
            r_counter <= '0;
            r_is_rem  <= bus.funct[1];
            r_neg_q   <= w_signed && (bus.operand1[WIDTH-1] ^ bus.operand2[WIDTH-1]);
            r_neg_r   <= w_signed && bus.operand1[WIDTH-1];
            r_divisor <= w_abs2;
            if (w_div_zero) begin
                r_special <= 1'b1;
                r_quot    <= '1;
                r_rem     <= bus.operand1;
            end else if (w_overflow) begin
                r_special <= 1'b1;
                r_quot    <= bus.operand1;
                r_rem     <= '0;
            end else begin
                r_special <= 1'b0;
                r_quot    <= w_abs1;
                r_rem     <= '0;
            end
        end else if (r_state == c_st_run) begin
            if (w_finish) begin
                r_result <= r_is_rem ? w_rem_fix : w_quot_fix;
            end else begin
                r_counter <= r_counter + 1'b1;
                if (!w_trial[WIDTH]) begin
                    r_rem  <= w_trial[WIDTH-1:0];
                    r_quot <= {r_quot[WIDTH-2:0], 1'b1};
                end else begin
                    r_rem  <= w_shift[WIDTH-1:0];
                    r_quot <= {r_quot[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign bus.result = r_result;
    assign bus.busy   = (r_state == c_st_run);
    assign bus.done   = (r_state == c_st_done);
endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider
// Purpose  : Directed self-checking bench for the sequential divider.
// Revision : 1.0
// ============================================================================
module tb_divider;
    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    divider_if #(.WIDTH(WIDTH)) bus ();

    divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation; lat counts edges after the accepting edge until done.
    task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        bus.start    = 1'b1;
        bus.funct    = f;
        bus.operand1 = a;
        bus.operand2 = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus.result;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.result !== 32'h0) $display("FAIL reset_result: got %h expected %h", bus.result, 32'h0); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else n_pass++;
    endtask

    task automatic test_unsigned();
        logic [31:0] r;
        int          lat;
        do_op(2'b01, 32'd100, 32'd7, r, lat);
        n_checks++; if (r !== 32'd14) $display("FAIL divu_100_7: got %h expected %h", r, 32'd14); else n_pass++;
        n_checks++; if (lat !== 33) $display("FAIL divu_latency: got %0d expected 33", lat); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL done_pulse_width: got %b expected 0", bus.done); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL busy_after_done: got %b expected 0", bus.busy); else n_pass++;
        n_checks++; if (bus.result !== 32'd14) $display("FAIL result_hold: got %h expected %h", bus.result, 32'd14); else n_pass++;
        do_op(2'b11, 32'd100, 32'd7, r, lat);
        n_checks++; if (r !== 32'd2) $display("FAIL remu_100_7: got %h expected %h", r, 32'd2); else n_pass++;
        n_checks++; if (lat !== 33) $display("FAIL remu_latency: got %0d expected 33", lat); else n_pass++;
    endtask

    task automatic test_signed();
        logic [31:0] r;
        int          lat;
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, r, lat);
        n_checks++; if (r !== 32'hFFFF_FFFD) $display("FAIL div_m7_2: got %h expected %h", r, 32'hFFFF_FFFD); else n_pass++;
        n_checks++; if (lat !== 33) $display("FAIL div_latency: got %0d expected 33", lat); else n_pass++;
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, r, lat);
        n_checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL rem_m7_2: got %h expected %h", r, 32'hFFFF_FFFF); else n_pass++;
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, r, lat);
        n_checks++; if (r !== 32'd1) $display("FAIL rem_7_m2: got %h expected %h", r, 32'd1); else n_pass++;
        do_op(2'b00, 32'd7, 32'hFFFF_FFFE, r, lat);
        n_checks++; if (r !== 32'hFFFF_FFFD) $display("FAIL div_7_m2: got %h expected %h", r, 32'hFFFF_FFFD); else n_pass++;
    endtask

    task automatic test_special();
        logic [31:0] r;
        int          lat;
        do_op(2'b00, 32'd5, 32'd0, r, lat);
        n_checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL div_by_zero: got %h expected %h", r, 32'hFFFF_FFFF); else n_pass++;
        n_checks++; if (lat !== 1) $display("FAIL div_by_zero_latency: got %0d expected 1", lat); else n_pass++;
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        n_checks++; if (r !== 32'h8000_0000) $display("FAIL div_overflow: got %h expected %h", r, 32'h8000_0000); else n_pass++;
        n_checks++; if (lat !== 1) $display("FAIL div_overflow_latency: got %0d expected 1", lat); else n_pass++;
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        n_checks++; if (r !== 32'h0) $display("FAIL rem_overflow: got %h expected %h", r, 32'h0); else n_pass++;
        n_checks++; if (lat !== 1) $display("FAIL rem_overflow_latency: got %0d expected 1", lat); else n_pass++;
        do_op(2'b11, 32'd5, 32'd0, r, lat);
        n_checks++; if (r !== 32'd5) $display("FAIL remu_by_zero: got %h expected %h", r, 32'd5); else n_pass++;
        n_checks++; if (lat !== 1) $display("FAIL remu_by_zero_latency: got %0d expected 1", lat); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.start    = 1'b1;
        bus.funct    = 2'b01;
        bus.operand1 = 32'hFFFF_FFFF;
        bus.operand2 = 32'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL busy_after_start: got %b expected 1", bus.busy); else n_pass++;
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 4) begin
                bus.start    = 1'b1;
                bus.funct    = 2'b01;
                bus.operand1 = 32'd10;
                bus.operand2 = 32'd2;
            end
            if (lat == 5) bus.start = 1'b0;
            if (lat == 20) begin
                n_checks++; if (bus.result !== 32'd5) $display("FAIL result_stable_in_run: got %h expected %h", bus.result, 32'd5); else n_pass++;
            end
        end
        n_checks++; if (bus.result !== 32'hFFFF_FFFF) $display("FAIL start_ignored_result: got %h expected %h", bus.result, 32'hFFFF_FFFF); else n_pass++;
        n_checks++; if (lat !== 33) $display("FAIL start_ignored_latency: got %0d expected 33", lat); else n_pass++;
        // Still in the done cycle: a new start must be accepted immediately.
        bus.start    = 1'b1;
        bus.funct    = 2'b01;
        bus.operand1 = 32'd9;
        bus.operand2 = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept: got busy %b expected 1", bus.busy); else n_pass++;
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++; if (bus.result !== 32'd4) $display("FAIL b2b_result: got %h expected %h", bus.result, 32'd4); else n_pass++;
        n_checks++; if (lat !== 33) $display("FAIL b2b_latency: got %0d expected 33", lat); else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        int          lat;
        bus.start    = 1'b1;
        bus.funct    = 2'b01;
        bus.operand1 = 32'd1000;
        bus.operand2 = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #4;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.result !== 32'h0) $display("FAIL async_reset_result: got %h expected %h", bus.result, 32'h0); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL async_reset_busy: got %b expected 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL async_reset_done: got %b expected 0", bus.done); else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_op(2'b01, 32'd9, 32'd3, r, lat);
        n_checks++; if (r !== 32'd3) $display("FAIL post_reset_divu: got %h expected %h", r, 32'd3); else n_pass++;
        n_checks++; if (lat !== 33) $display("FAIL post_reset_latency: got %0d expected 33", lat); else n_pass++;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.funct    = 2'b00;
        bus.operand1 = '0;
        bus.operand2 = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        test_unsigned();
        test_signed();
        test_special();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
